// File: rtl/counter_4.sv
// counter_4 : 4-bit universal counter / shift register.
//
// Eight operations are selected by Mode on every rising Ck edge: hold,
// parallel load, count up/down (mod 16), shift right/left with serial
// fill, and rotate right/left. Out is the state register itself, so
// nothing on the inputs reaches Out without passing through a clock edge.
//
// Ports
//   Ck     in   1  clock, rising edge active
//   Reset  in   1  synchronous active-high clear (wins over Mode)
//   Mode   in   3  operation select
//   Din    in   4  parallel load data (load)
//   R_In   in   1  serial input entering bit 3 (shift right)
//   L_In   in   1  serial input entering bit 0 (shift left)
//   Out    out  4  registered value
module counter_4 (
    input  logic       Ck,
    input  logic       Reset,
    input  logic [2:0] Mode,
    input  logic [3:0] Din,
    input  logic       R_In,
    input  logic       L_In,
    output logic [3:0] Out
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_UP   = 3'b010,
        MODE_DOWN = 3'b011,
        MODE_SHR  = 3'b100,
        MODE_SHL  = 3'b101,
        MODE_ROR  = 3'b110,
        MODE_ROL  = 3'b111
    } mode_e;

    logic [3:0] q;
    logic [3:0] q_next;

    // Next-state selection; every Mode code is legal, so the default arm
    // only exists to keep the hold behaviour explicit for unknown inputs.
    always_comb begin
        q_next = q;
        case (mode_e'(Mode))
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = Din;
            MODE_UP:   q_next = q + 4'd1;          // wraps 1111 -> 0000
            MODE_DOWN: q_next = q - 4'd1;          // wraps 0000 -> 1111
            MODE_SHR:  q_next = {R_In, q[3:1]};
            MODE_SHL:  q_next = {q[2:0], L_In};
            MODE_ROR:  q_next = {q[0], q[3:1]};
            MODE_ROL:  q_next = {q[2:0], q[3]};
            default:   q_next = q;
        endcase
    end

    always_ff @(posedge Ck) begin
        if (Reset)
            q <= 4'b0000;
        else
            q <= q_next;
    end

    assign Out = q;

endmodule

// File: tb/tb_counter_4.sv
module tb_counter_4;

    logic       Ck;
    logic       Reset;
    logic [2:0] Mode;
    logic [3:0] Din;
    logic       R_In;
    logic       L_In;
    logic [3:0] Out;

    int errors = 0;
    int checks = 0;

    counter_4 dut (
        .Ck    (Ck),
        .Reset (Reset),
        .Mode  (Mode),
        .Din   (Din),
        .R_In  (R_In),
        .L_In  (L_In),
        .Out   (Out)
    );

    initial begin
        Ck = 1'b0;
        forever #5 Ck = ~Ck;
    end

    typedef struct {
        logic       rst;
        logic [2:0] mode;
        logic [3:0] din;
        logic       rin;
        logic       lin;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Reference: the mode table written as plain integer arithmetic.
    function automatic int model(input int q, input int rst, input int mode,
                                 input int din, input int rin, input int lin);
        if (rst != 0) return 0;
        case (mode)
            0: return q;
            1: return din;
            2: return (q + 1) % 16;
            3: return (q + 15) % 16;
            4: return q / 2 + rin * 8;
            5: return (q * 2) % 16 + lin;
            6: return q / 2 + (q % 2) * 8;
            7: return (q * 2) % 16 + q / 8;
            default: return q;
        endcase
    endfunction

    task automatic check(input string name, input logic [3:0] exp);
        checks++;
        if (Out !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, Out, exp, $time);
        end
    endtask

    // Inputs change on the falling edge, Out is sampled 1ns after the rising edge.
    task automatic step(input logic rst, input logic [2:0] mode, input logic [3:0] din,
                        input logic rin, input logic lin);
        @(negedge Ck);
        Reset = rst; Mode = mode; Din = din; R_In = rin; L_In = lin;
        @(posedge Ck);
        #1;
    endtask

    initial begin
        int q;
        int r_rst, r_mode, r_din, r_rin, r_lin;

        Reset = 1'b1; Mode = 3'b010; Din = 4'b1010; R_In = 1'b0; L_In = 1'b0;

        // reset, load/hold, count wrap, shift, rotate
        vecs.push_back('{1'b1, 3'd2, 4'b1010, 1'b0, 1'b0, 4'b0000});
        vecs.push_back('{1'b1, 3'd2, 4'b1010, 1'b0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 3'd2, 4'b1010, 1'b0, 1'b0, 4'b0001});
        vecs.push_back('{1'b0, 3'd1, 4'b1011, 1'b0, 1'b0, 4'b1011});
        vecs.push_back('{1'b0, 3'd0, 4'b0000, 1'b1, 1'b0, 4'b1011});
        vecs.push_back('{1'b0, 3'd0, 4'b1111, 1'b0, 1'b1, 4'b1011});
        vecs.push_back('{1'b0, 3'd0, 4'b0101, 1'b1, 1'b1, 4'b1011});
        vecs.push_back('{1'b0, 3'd1, 4'b1110, 1'b0, 1'b0, 4'b1110});
        vecs.push_back('{1'b0, 3'd2, 4'b0000, 1'b1, 1'b1, 4'b1111});
        vecs.push_back('{1'b0, 3'd2, 4'b0000, 1'b0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 3'd2, 4'b0111, 1'b0, 1'b0, 4'b0001});
        vecs.push_back('{1'b0, 3'd1, 4'b0001, 1'b0, 1'b0, 4'b0001});
        vecs.push_back('{1'b0, 3'd3, 4'b0000, 1'b0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 3'd3, 4'b0000, 1'b1, 1'b1, 4'b1111});
        vecs.push_back('{1'b0, 3'd3, 4'b1001, 1'b0, 1'b0, 4'b1110});
        vecs.push_back('{1'b0, 3'd1, 4'b0110, 1'b0, 1'b0, 4'b0110});
        vecs.push_back('{1'b0, 3'd4, 4'b0000, 1'b1, 1'b0, 4'b1011});
        vecs.push_back('{1'b0, 3'd4, 4'b1111, 1'b0, 1'b1, 4'b0101});
        vecs.push_back('{1'b0, 3'd5, 4'b0000, 1'b0, 1'b1, 4'b1011});
        vecs.push_back('{1'b0, 3'd5, 4'b1111, 1'b1, 1'b0, 4'b0110});
        vecs.push_back('{1'b0, 3'd1, 4'b1001, 1'b0, 1'b0, 4'b1001});
        vecs.push_back('{1'b0, 3'd6, 4'b0000, 1'b0, 1'b0, 4'b1100});
        vecs.push_back('{1'b0, 3'd6, 4'b0000, 1'b0, 1'b0, 4'b0110});
        vecs.push_back('{1'b0, 3'd7, 4'b0000, 1'b0, 1'b0, 4'b1100});
        vecs.push_back('{1'b0, 3'd7, 4'b0000, 1'b0, 1'b0, 4'b1001});
        vecs.push_back('{1'b0, 3'd6, 4'b1111, 1'b1, 1'b1, 4'b1100});
        vecs.push_back('{1'b0, 3'd6, 4'b1111, 1'b1, 1'b1, 4'b0110});
        vecs.push_back('{1'b0, 3'd7, 4'b1111, 1'b1, 1'b1, 4'b1100});
        vecs.push_back('{1'b0, 3'd7, 4'b1111, 1'b1, 1'b1, 4'b1001});

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].mode, vecs[i].din, vecs[i].rin, vecs[i].lin);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset in the middle of counting, then restart by counting down from 0.
        step(1'b0, 3'd1, 4'b0101, 1'b0, 1'b0); check("mid_load", 4'b0101);
        step(1'b0, 3'd2, 4'b0000, 1'b0, 1'b0); check("mid_up", 4'b0110);
        step(1'b1, 3'd2, 4'b1111, 1'b1, 1'b1); check("mid_reset", 4'b0000);
        step(1'b0, 3'd3, 4'b0000, 1'b0, 1'b0); check("post_reset_down", 4'b1111);
        step(1'b0, 3'd4, 4'b0000, 1'b1, 1'b0); check("post_reset_shr", 4'b1111);

        // Random regression against the reference model, one reset pulse mid-run.
        q = 15;
        for (int c = 0; c < 40; c++) begin
            r_rst  = (c == 20) ? 1 : 0;
            r_mode = int'($urandom_range(0, 7));
            r_din  = int'($urandom_range(0, 15));
            r_rin  = int'($urandom_range(0, 1));
            r_lin  = int'($urandom_range(0, 1));
            q = model(q, r_rst, r_mode, r_din, r_rin, r_lin);
            step(r_rst[0], r_mode[2:0], r_din[3:0], r_rin[0], r_lin[0]);
            check($sformatf("rand%0d_m%0d_r%0d", c, r_mode, r_rst), q[3:0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
